// File: rtl/fft8_pkg.sv
// Shared types and constants for the fft8 frame sequencer slice.
package fft8_pkg;

  localparam int unsigned INT_W  = 8;
  localparam int unsigned FRAC_W = 8;

  // Q8.8 fixed-point word, bit range [INT_W-1:-FRAC_W]
  typedef logic [INT_W-1:-FRAC_W] fixed_t;

  localparam int unsigned FFT_N = 8;
  localparam int unsigned IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    FILL,
    LAUNCH,
    WAIT,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/fft8_frame_buf.sv
// 8-entry fixed_t register file; LANES words per entry. Single-entry write
// port plus a whole-frame parallel load, and a parallel read-all output.
module fft8_frame_buf
  import fft8_pkg::*;
#(
  parameter int unsigned LANES = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en_i,
  input  idx_t                            wr_idx_i,
  input  fixed_t [LANES-1:0]              wr_data_i,
  input  logic                            ld_en_i,
  input  fixed_t [FFT_N-1:0][LANES-1:0]   ld_data_i,
  output fixed_t [FFT_N-1:0][LANES-1:0]   rd_all_o
);

  fixed_t [FFT_N-1:0][LANES-1:0] mem_q;

  // storage: cleared by reset, whole-frame load wins over single write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (ld_en_i) begin
      mem_q <= ld_data_i;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_all_o = mem_q;

endmodule

// File: rtl/fft8_frame_sequencer.sv
// Frame sequencer for the fft8 core: collects 8 samples, pulses the core,
// captures its results and streams them out one bin per beat.
// Optional watchdog on the WAIT state: define FFT8_SEQ_TIMEOUT_EN.
module fft8_frame_sequencer
  import fft8_pkg::*;
`ifdef FFT8_SEQ_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 10
)
`endif
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  fixed_t               s_data,
  output fixed_t [FFT_N-1:0]   fft_x,
  output logic                 fft_start,
  input  fixed_t [FFT_N-1:0]   fft_y,
  input  fixed_t [FFT_N-1:0]   fft_yi,
  input  logic                 fft_done,
  output logic                 m_valid,
  input  logic                 m_ready,
  output fixed_t               m_re,
  output fixed_t               m_im,
  output idx_t                 m_idx,
  output logic                 m_last,
  output logic                 busy,
  output logic                 err_timeout
);

  seq_state_t state_q, state_d;
  idx_t       wr_idx_q, wr_idx_d;
  idx_t       rd_idx_q, rd_idx_d;
  logic       samp_we;
  logic       res_ld;

  fixed_t [FFT_N-1:0][0:0] samp_all;
  fixed_t [FFT_N-1:0][1:0] res_all;
  fixed_t [FFT_N-1:0][1:0] res_ld_data;

`ifdef FFT8_SEQ_TIMEOUT_EN
  localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
`endif

  fft8_frame_buf #(.LANES(1)) u_samp_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (samp_we),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (s_data),
    .ld_en_i   (1'b0),
    .ld_data_i ('0),
    .rd_all_o  (samp_all)
  );

  // results stored as {im, re} pairs, loaded as a whole frame
  fft8_frame_buf #(.LANES(2)) u_res_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (1'b0),
    .wr_idx_i  ('0),
    .wr_data_i ('0),
    .ld_en_i   (res_ld),
    .ld_data_i (res_ld_data),
    .rd_all_o  (res_all)
  );

  // unpack sample buffer to the core and pack core outputs into result pairs
  always_comb begin
    fft_x       = '0;
    res_ld_data = '0;
    for (int unsigned k = 0; k < FFT_N; k++) begin
      fft_x[k]          = samp_all[k][0];
      res_ld_data[k][0] = fft_y[k];
      res_ld_data[k][1] = fft_yi[k];
    end
  end

  // state and index registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FILL;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
`ifdef FFT8_SEQ_TIMEOUT_EN
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
`ifdef FFT8_SEQ_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // next-state logic and buffer write strobes
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    samp_we  = 1'b0;
    res_ld   = 1'b0;
`ifdef FFT8_SEQ_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      FILL: begin
        if (s_valid) begin
          samp_we  = 1'b1;
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == idx_t'(FFT_N - 1)) state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
`ifdef FFT8_SEQ_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (fft_done) begin
          res_ld  = 1'b1;
          state_d = DRAIN;
        end
`ifdef FFT8_SEQ_TIMEOUT_EN
        // counter holds completed WAIT cycles, so TIMEOUT_CYCLES-1 marks the last one
        else if (wait_cnt_q == WCNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = FILL;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (m_ready) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == idx_t'(FFT_N - 1)) state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign s_ready   = rst_n && (state_q == FILL);
  assign fft_start = rst_n && (state_q == LAUNCH);
  assign m_valid   = rst_n && (state_q == DRAIN);
  assign busy      = rst_n && (state_q != FILL);
  assign m_last    = m_valid && (rd_idx_q == idx_t'(FFT_N - 1));
  assign m_re      = res_all[rd_idx_q][0];
  assign m_im      = res_all[rd_idx_q][1];
  assign m_idx     = rd_idx_q;

`ifdef FFT8_SEQ_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Self-checking bench for fft8_frame_sequencer with a stub fft8 core.
module tb_fft8_frame_sequencer;
  import fft8_pkg::*;

  typedef struct packed {
    fixed_t     re;
    fixed_t     im;
    logic [2:0] idx;
    logic       lst;
  } bin_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_valid;
  logic               s_ready;
  fixed_t             s_data;
  fixed_t [FFT_N-1:0] fft_x;
  logic               fft_start;
  fixed_t [FFT_N-1:0] fft_y;
  fixed_t [FFT_N-1:0] fft_yi;
  logic               fft_done;
  logic               m_valid;
  logic               m_ready = 1'b1;
  fixed_t             m_re;
  fixed_t             m_im;
  idx_t               m_idx;
  logic               m_last;
  logic               busy;
  logic               err_timeout;

  always #5 clk = ~clk;

  fft8_frame_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .fft_x       (fft_x),
    .fft_start   (fft_start),
    .fft_y       (fft_y),
    .fft_yi      (fft_yi),
    .fft_done    (fft_done),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_re        (m_re),
    .m_im        (m_im),
    .m_idx       (m_idx),
    .m_last      (m_last),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic void fail(input string name);
    n_chk++;
    $display("FAIL %s: got no/unexpected event, expected the specified event", name);
  endfunction

  // cycle counter
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stub core: done 3 cycles after start, y = x, yi = -x; spur forces a stray done
  int   stub_cnt = 0;
  logic stub_en  = 1'b1;
  logic spur     = 1'b0;
  always @(posedge clk) begin
    if (!rst_n)                   stub_cnt <= 0;
    else if (fft_start && stub_en) stub_cnt <= 3;
    else if (stub_cnt != 0)        stub_cnt <= stub_cnt - 1;
  end
  assign fft_done = (stub_cnt == 1) || spur;
  always_comb begin
    for (int k = 0; k < FFT_N; k++) begin
      fft_y[k]  = spur ? 16'h5A5A : fft_x[k];
      fft_yi[k] = spur ? 16'hA5A5 : 16'(-fft_x[k]);
    end
  end

  // result-side ready pattern: 0 = always, 1 = 1,0,0,1 repeating, 2 = stalled
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: m_ready = 1'b0;
    endcase
  end

  // scoreboards
  bin_t         exp_q[$];
  logic [127:0] frame_q[$];
  int           acc8_cyc      = 0;
  int           first_acc_cyc = 0;
  int           start_cyc     = 0;
  int           last_hs_cyc   = 0;
  int           n_start       = 0;
  int           frames_sent   = 0;
  int           last_wait     = 0;
  logic         prev_start    = 1'b0;

  // monitor: start pulse timing / frame contents, and every valid result beat
  always @(negedge clk) begin
    logic [127:0] f;
    bin_t         e;
    if (fft_start) begin
      n_start++;
      start_cyc = cyc;
      check("start_single", {127'd0, prev_start}, 128'd0);
      check("start_latency", cyc, acc8_cyc);
      if (frame_q.size() == 0) fail("start_unexpected");
      else begin
        f = frame_q.pop_front();
        check("fft_x", fft_x, f);
      end
    end
    prev_start = fft_start;
    if (m_valid) begin
      if (exp_q.size() == 0) fail("m_valid_unexpected");
      else begin
        e = exp_q[0];
        check("bin", {m_re, m_im, m_idx, m_last}, e);
        if (m_ready) begin
          void'(exp_q.pop_front());
          if (m_last) last_hs_cyc = cyc + 1;
        end
      end
    end else begin
      check("m_last_without_valid", {127'd0, m_last}, 128'd0);
    end
  end

  int           nfill = 0;
  logic [127:0] frm_bits = '0;
  bit           expect_bins = 1'b1;

  task automatic push(input fixed_t d);
    int   t = 0;
    bin_t b;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail("s_ready_timeout");
    last_wait = t;
    @(posedge clk);
    #1;
    if (nfill == 0) first_acc_cyc = cyc;
    frm_bits[nfill*16 +: 16] = d;
    nfill++;
    if (nfill == 8) begin
      acc8_cyc = cyc;
      frames_sent++;
      frame_q.push_back(frm_bits);
      if (expect_bins) begin
        for (int k = 0; k < 8; k++) begin
          b.re  = frm_bits[k*16 +: 16];
          b.im  = 16'(-frm_bits[k*16 +: 16]);
          b.idx = 3'(k);
          b.lst = (k == 7);
          exp_q.push_back(b);
        end
      end
      nfill = 0;
    end
  endtask

  task automatic push_frame(input fixed_t base, input fixed_t step);
    fixed_t v;
    v = base;
    for (int k = 0; k < 8; k++) begin
      push(v);
      v = v + step;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail("drain_timeout");
  endtask

  task automatic check_reset_outputs();
    check("rst_s_ready",   {127'd0, s_ready},     128'd0);
    check("rst_fft_start", {127'd0, fft_start},   128'd0);
    check("rst_m_valid",   {127'd0, m_valid},     128'd0);
    check("rst_m_last",    {127'd0, m_last},      128'd0);
    check("rst_busy",      {127'd0, busy},        128'd0);
    check("rst_err",       {127'd0, err_timeout}, 128'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    check("rst_fft_x", fft_x, 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", {127'd0, s_ready}, 128'd1);

    // 1: basic frame 1..8, ready always high
    push_frame(16'h0100, 16'h0100);
    s_valid = 1'b0;
    wait_drain();

    // 2: same frame with m_ready stalling 1,0,0,1,...
    ready_mode = 1;
    push_frame(16'h0100, 16'h0100);
    s_valid = 1'b0;
    wait_drain();
    ready_mode = 0;
    @(posedge clk);
    #1;

    // 3: s_valid held high across two frames
    push_frame(16'h8000, 16'h0F0F);
    push(16'h7FFF);
    check("held_valid_wait", last_wait, 13);
    check("frame_gap", first_acc_cyc, last_hs_cyc + 1);
    for (int k = 1; k < 8; k++) push(16'h7FFF - 16'(k * 16'h0123));
    s_valid = 1'b0;
    wait_drain();

    // 4: reset after 5 accepted samples, then a complete frame
    for (int k = 0; k < 5; k++) push(16'h1111 * 16'(k + 1));
    s_valid = 1'b0;
    rst_n   = 1'b0;
    nfill   = 0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_fft_x", fft_x, 128'd0);
    push_frame(16'hFFF0, 16'hFFFD);
    s_valid = 1'b0;
    wait_drain();

    // 5: stray fft_done during FILL and during DRAIN
    for (int k = 0; k < 3; k++) push(16'h0A00 + 16'(k));
    s_valid = 1'b0;
    @(posedge clk);
    #2;
    spur = 1'b1;
    @(posedge clk);
    #2;
    spur = 1'b0;
    @(negedge clk);
    check("fill_done_busy", {127'd0, busy}, 128'd0);
    check("fill_done_ready", {127'd0, s_ready}, 128'd1);
    for (int k = 3; k < 8; k++) push(16'h0A00 + 16'(k));
    s_valid = 1'b0;
    t = 0;
    while (!m_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) fail("drain_entry_timeout");
    ready_mode = 2;
    @(posedge clk);
    #2;
    spur = 1'b1;
    @(posedge clk);
    #2;
    spur = 1'b0;
    repeat (2) @(negedge clk);
    ready_mode = 0;
    wait_drain();

`ifdef FFT8_SEQ_TIMEOUT_EN
    // 6: core never answers -> watchdog, then a good frame with sticky error
    stub_en     = 1'b0;
    expect_bins = 1'b0;
    push_frame(16'h0300, 16'h0010);
    s_valid = 1'b0;
    t = 0;
    while (!err_timeout && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail("timeout_never");
    else begin
      check("timeout_cycle", cyc, start_cyc + 11);
      check("timeout_to_fill", {127'd0, busy}, 128'd0);
    end
    stub_en     = 1'b1;
    expect_bins = 1'b1;
    push_frame(16'h0200, 16'h0200);
    s_valid = 1'b0;
    wait_drain();
    check("err_sticky", {127'd0, err_timeout}, 128'd1);
`else
    check("err_tied_low", {127'd0, err_timeout}, 128'd0);
`endif

    repeat (3) @(negedge clk);
    check("start_count", n_start, frames_sent);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft8_frame_sequencer.md
Name: fft8_frame_sequencer

Overview:
Sequences the 8-point fixed-point FFT core (fft8).
- Collects a serial stream of Q8.8 real samples into an 8-sample frame.
- Launches the core with a one-cycle start pulse and waits for its result-valid strobe.
- Captures the 8 complex results and streams them out one bin per beat under valid/ready backpressure.
- Sits between the sample source and the fft8 core, and owns the core's isValid input.

Parameters:
INT_W, 8, integer bits of a fixed-point word (bit range [INT_W-1:-FRAC_W])
FRAC_W, 8, fractional bits of a fixed-point word
TIMEOUT_CYCLES, 10, maximum WAIT cycles before a frame is abandoned (used only with the optional feature)

Ports:
clk  in  1  single clock; everything is on its rising edge
rst_n  in  1  reset: synchronous, active-low
s_valid  in  1  input sample valid
s_ready  out  1  input sample ready
s_data  in  16  input sample, Q8.8 real
fft_x  out  8x16  frame presented to fft8 inputs x[0..7]
fft_start  out  1  drives fft8 isValid
fft_y  in  8x16  fft8 real outputs y[0..7]
fft_yi  in  8x16  fft8 imaginary outputs yi[0..7]
fft_done  in  1  fft8 resultValid
m_valid  out  1  result valid
m_ready  in  1  result ready
m_re  out  16  real part of current bin, Q8.8
m_im  out  16  imaginary part of current bin, Q8.8
m_idx  out  3  bin index 0..7
m_last  out  1  high with bin 7
busy  out  1  high in any state other than FILL
err_timeout  out  1  sticky watchdog error

Behaviour:
- States: FILL, LAUNCH, WAIT, DRAIN. Reset state is FILL.
- rst_n low at a clock edge clears:
  - state to FILL; wr_idx and rd_idx to 0;
  - sample and result buffers to 0;
  - err_timeout to 0.
- Outputs while rst_n is low: s_ready=0, fft_start=0, m_valid=0, m_last=0, busy=0.
- Reset mid-operation discards any partial frame or results. A fft_done arriving after such a reset is ignored.
- FILL:
  - s_ready=1.
  - On s_valid&&s_ready, write s_data to buf[wr_idx] and increment wr_idx.
  - Accepting the 8th sample (wr_idx==7) wraps wr_idx to 0 and moves to LAUNCH.
- LAUNCH:
  - fft_start=1 for exactly one cycle, then go to WAIT.
  - fft_x = buf[0..7]. The buffer is written only in FILL, so fft_x is stable from LAUNCH through DRAIN.
- WAIT:
  - On fft_done, register fft_y/fft_yi into res_re/res_im[0..7], then go to DRAIN.
  - fft_done outside WAIT is ignored.
- DRAIN:
  - m_valid=1; m_re=res_re[rd_idx], m_im=res_im[rd_idx], m_idx=rd_idx, m_last=(rd_idx==7).
  - On m_valid&&m_ready, increment rd_idx.
  - The handshake on bin 7 wraps rd_idx to 0 and returns to FILL.
  - While m_ready is low, outputs hold stable.
- s_ready=0 in LAUNCH, WAIT and DRAIN. There is no frame overlap: a held s_valid is not consumed until FILL is re-entered.
- Latency:
  - 8th sample accepted at edge T gives fft_start high in cycle T+1.
  - fft_done sampled in WAIT at edge D gives m_valid high from cycle D+1.
- Arithmetic: pure transport. No scaling, rounding or sign manipulation. Widths are fixed at INT_W+FRAC_W=16.

Optional Feature:
Macro: FFT8_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without fft_done.
  - When it reaches TIMEOUT_CYCLES, set err_timeout (sticky until reset), discard the frame, and return to FILL without asserting m_valid.
  - fft_done on the same cycle as expiry takes priority and goes to DRAIN.
- Not defined: WAIT is unbounded, the counter is not built, and err_timeout is tied 0.

Decomposition:
- Shared package fft8_pkg holds:
  - typedef fixed_t = logic [INT_W-1:-FRAC_W];
  - FFT_N=8 and its index width (3);
  - the state enum seq_state_t {FILL, LAUNCH, WAIT, DRAIN}.
- One sub-module, fft8_frame_buf: an 8-entry fixed_t register file with a write port and a parallel read-all output. Instantiated twice: samples, and results (real and imaginary as a pair).

Test Plan:
- Frame of samples 1..8 (0x0100..0x0800), m_ready=1, stub core asserts done 3 cycles after start with y=x, yi=-x. Required:
  - fft_x[k]=0x0100*(k+1);
  - exactly one fft_start pulse, in the cycle after the 8th accept;
  - m_idx 0..7 with m_re=0x0100..0x0800 and m_im=0xFF00..0xF800;
  - m_last only with idx 7.
- Same frame with m_ready toggling 1,0,0,1,… -> m_re/m_im/m_idx held during stalls; all 8 bins delivered once, in order.
- s_valid held high throughout two frames -> s_ready low from LAUNCH until DRAIN completes; the second frame starts exactly 1 cycle after the bin-7 handshake; no sample lost or duplicated.
- With FFT8_SEQ_TIMEOUT_EN, stub never asserts done -> err_timeout rises after 10 WAIT cycles; state returns to FILL; m_valid never asserted; err_timeout stays high through a following good frame.
- rst_n pulsed low for 1 cycle after 5 accepted samples -> all outputs at reset values; the next 8 samples form a complete frame processed correctly.
- fft_done pulsed during FILL and during DRAIN -> no state change and no result overwrite.
